reg_alu: RTL and testbench
==========================

Name: reg_alu

Overview:
- Button-stepped 16x16-bit register file with a 16-bit ALU, used for manual, step-by-step execution on an FPGA board.
- Each 16-bit instruction on INS runs in three button presses: FETCH, EXEC, WRITEBACK.
- OUT shows the value from the most recent step; it drives board LEDs/display.

Parameters:
- none (data width 16 and register count 16 are fixed by the instruction format)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- INS  input  16  instruction: [15:12] opcode, [11:8] rs, [7:4] rt, [3:0] rd
- btn  input  1  step button; asynchronous to clk, pulse of at least 1 clk period
- OUT  output  16  registered display value

Behaviour:
- Reset (rst=0, asynchronous):
  - R[i] <= i for i=0..15 (16-bit).
  - IR, A, B, RES <= 0; OUT <= 0; phase <= FETCH; synchronizer flops <= 0.
- btn handling:
  - btn passes a 2-flop synchronizer, then a third flop for rising-edge detect.
  - step = s2 & ~s3.
  - Holding btn high gives exactly one step; the next step needs btn low for at least 1 clk.
- Step latency: the step action and the OUT update happen on the 3rd rising clk edge, counting from the first edge that samples btn=1.
- Phase FSM, advancing only on step: FETCH -> EXEC -> WB -> FETCH.
  - FETCH: IR <= INS; A <= R[INS[11:8]]; B <= R[INS[7:4]]; OUT <= R[INS[11:8]]. INS is ignored outside FETCH.
  - EXEC: RES <= alu(IR[15:12], A, B); OUT <= alu result.
  - WB: R[IR[3:0]] <= RES; OUT <= RES.
- ALU is 16-bit; results are truncated mod 2^16. Opcodes:
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR
  - 5 NOT A; 6 SLL A<<B[3:0]; 7 SRL A>>B[3:0]; 8 SRA (arithmetic) A>>>B[3:0]
  - 9 INC A+1; 10 DEC A-1; 11 SLT (signed A<B ? 1 : 0); 12 MOV A
  - 13 LI zero-extended {IR[11:8], IR[7:4]}; 14 NOR; 15 NAND
- Register-file reads are combinational and writes are synchronous.
- rd may equal rs or rt. The new value is visible at the next FETCH; there is no hazard because phases are sequential.
- Reset mid-instruction: the instruction is abandoned with no write; the FSM returns to FETCH and registers reload their reset values.

Optional Feature:
- Macro: REG_ALU_FLAGS_EN.
- With macro:
  - Extra output port FLAGS [3:0] = {Z, N, C, V}, updated at EXEC only and reset to 0.
  - Z: result==0. N: result[15].
  - C: carry-out for ADD/INC, borrow for SUB/DEC; 0 otherwise.
  - V: signed overflow for ADD/SUB/INC/DEC; 0 otherwise.
- Without macro: no FLAGS port and no flag logic.

Test Plan:
- Reset, then INS=0x0234 (ADD R4=R2+R3), 3 steps -> OUT=0x0002, then 0x0005, then 0x0005; R4=5.
- Next INS=0x1414 (SUB R4=R4-R1), 3 steps -> OUT=0x0005, 0x0004, 0x0004. Repeat the same instruction -> OUT=0x0004, 0x0003, 0x0003.
- Change INS during EXEC/WB -> no effect. Hold btn high for 10 clks -> exactly one step.
- SUB R0=R0-R1 (0x1010) -> RES=0xFFFF. With FLAGS_EN: N=1, C=1 (borrow), Z=0, V=0.
- SRA with A=0x8000, B=4 -> 0xF800. LI with INS=0xDAB5 -> R5=0x00AB.
- Assert rst low during EXEC -> OUT=0, rd unmodified (holds reset value), next step performs FETCH.

Source files
------------

// File: rtl/reg_alu.sv
// reg_alu: button-stepped 16x16-bit register file with a 16-bit ALU.
// Each instruction on INS runs in three button steps (FETCH, EXEC, WB);
// OUT shows the value produced by the most recent step.
// Optional feature macro: REG_ALU_FLAGS_EN adds a FLAGS[3:0] = {Z,N,C,V}
// output updated at EXEC.
//
// Handshake note: there is no valid/ready pair here. The only "transfer" is
// a step, a single-cycle pulse derived from the rising edge of the
// synchronized button; every state change happens on a cycle where step=1.
module reg_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] INS,
  input  logic        btn,
  output logic [15:0] OUT
`ifdef REG_ALU_FLAGS_EN
  ,
  output logic [3:0]  FLAGS
`endif
);

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_WB    = 2'd2
  } phase_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_DEC  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_MOV  = 4'd12;
  localparam logic [3:0] OP_LI   = 4'd13;
  localparam logic [3:0] OP_NOR  = 4'd14;
  localparam logic [3:0] OP_NAND = 4'd15;

  // Phase state, kept in a named enum so checkers can bind to phase_q.
  phase_e       phase_q, phase_d;

  logic         s1_q, s2_q, s3_q;
  logic         step;

  logic [15:0]  rf_q [16];
  logic [15:0]  ir_q, a_q, b_q, res_q, out_q;
  logic [15:0]  alu_res;
  logic [3:0]   opcode;
  logic [3:0]   rs_idx, rt_idx, rd_idx;

  assign opcode = ir_q[15:12];
  assign rd_idx = ir_q[3:0];
  assign rs_idx = INS[11:8];
  assign rt_idx = INS[7:4];
  assign OUT    = out_q;

  // Button synchronizer (two flops) plus one flop for rising-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // One pulse per press, however long the button is held.
  assign step = s2_q & ~s3_q;

  // Phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= PH_FETCH;
    else      phase_q <= phase_d;
  end

  // Next phase: advance around FETCH -> EXEC -> WB only on a step.
  always_comb begin
    phase_d = phase_q;
    if (step) begin
      case (phase_q)
        PH_FETCH: phase_d = PH_EXEC;
        PH_EXEC:  phase_d = PH_WB;
        PH_WB:    phase_d = PH_FETCH;
        default:  phase_d = PH_FETCH;
      endcase
    end
  end

  // ALU on the latched operands; all results wrap modulo 2^16.
  always_comb begin
    alu_res = 16'h0000;
    case (opcode)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_SLL:  alu_res = a_q << b_q[3:0];
      OP_SRL:  alu_res = a_q >> b_q[3:0];
      OP_SRA:  alu_res = $signed(a_q) >>> b_q[3:0];
      OP_INC:  alu_res = a_q + 16'd1;
      OP_DEC:  alu_res = a_q - 16'd1;
      OP_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? 16'd1 : 16'd0;
      OP_MOV:  alu_res = a_q;
      OP_LI:   alu_res = {8'h00, ir_q[11:8], ir_q[7:4]};
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_NAND: alu_res = ~(a_q & b_q);
      default: alu_res = 16'h0000;
    endcase
  end

  // Datapath registers: capture at FETCH, compute at EXEC, show at WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q  <= 16'h0000;
      a_q   <= 16'h0000;
      b_q   <= 16'h0000;
      res_q <= 16'h0000;
      out_q <= 16'h0000;
    end else if (step) begin
      case (phase_q)
        PH_FETCH: begin
          ir_q  <= INS;
          a_q   <= rf_q[rs_idx];
          b_q   <= rf_q[rt_idx];
          out_q <= rf_q[rs_idx];
        end
        PH_EXEC: begin
          res_q <= alu_res;
          out_q <= alu_res;
        end
        PH_WB: begin
          out_q <= res_q;
        end
        default: ;
      endcase
    end
  end

  // Register file: reset to R[i] = i, single write port used at WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= 16'(i);
    end else if (step && (phase_q == PH_WB)) begin
      rf_q[rd_idx] <= res_q;
    end
  end

`ifdef REG_ALU_FLAGS_EN
  logic [3:0] flags_q;
  logic       flag_c, flag_v;
  logic [16:0] add_ext;

  assign FLAGS = flags_q;

  // Carry/borrow and signed overflow, only meaningful for add/sub family.
  always_comb begin
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    add_ext = {1'b0, a_q} + {1'b0, b_q};
    case (opcode)
      OP_ADD: begin
        flag_c = add_ext[16];
        flag_v = (a_q[15] == b_q[15]) && (alu_res[15] != a_q[15]);
      end
      OP_SUB: begin
        flag_c = (a_q < b_q);
        flag_v = (a_q[15] != b_q[15]) && (alu_res[15] != a_q[15]);
      end
      OP_INC: begin
        flag_c = (a_q == 16'hFFFF);
        flag_v = (a_q == 16'h7FFF);
      end
      OP_DEC: begin
        flag_c = (a_q == 16'h0000);
        flag_v = (a_q == 16'h8000);
      end
      default: begin
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
    endcase
  end

  // Flags latch together with RES at the EXEC step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 4'h0;
    end else if (step && (phase_q == PH_EXEC)) begin
      flags_q <= {(alu_res == 16'h0000), alu_res[15], flag_c, flag_v};
    end
  end
`endif

endmodule

// File: tb/tb_reg_alu.sv
// Directed bench for reg_alu: hand-computed OUT values for each step.
module tb_reg_alu;

  logic        clk;
  logic        rst;
  logic [15:0] INS;
  logic        btn;
  logic [15:0] OUT;
`ifdef REG_ALU_FLAGS_EN
  logic [3:0]  FLAGS;
`endif

  int n_cmp;
  int n_err;

  reg_alu dut (
    .clk (clk),
    .rst (rst),
    .INS (INS),
    .btn (btn),
    .OUT (OUT)
`ifdef REG_ALU_FLAGS_EN
    ,
    .FLAGS (FLAGS)
`endif
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Press the button for hold_clks cycles, release, let the step settle.
  task automatic press(input int hold_clks);
    @(negedge clk);
    btn = 1'b1;
    repeat (hold_clks) @(negedge clk);
    btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One full instruction: three steps with expected OUT after each.
  task automatic run_ins(input string tag, input logic [15:0] ins,
                         input logic [15:0] e_f, input logic [15:0] e_x,
                         input logic [15:0] e_w);
    INS = ins;
    press(1);
    check_eq({tag, "_fetch"}, OUT, e_f);
    press(1);
    check_eq({tag, "_exec"}, OUT, e_x);
    press(1);
    check_eq({tag, "_wb"}, OUT, e_w);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] e_f;
    logic [15:0] e_x;
  } vec_t;

  vec_t vecs [12];

  initial begin
    n_cmp = 0;
    n_err = 0;
    btn   = 1'b0;
    INS   = 16'h0000;
    rst   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check_eq("reset_out", OUT, 16'h0000);
`ifdef REG_ALU_FLAGS_EN
    check_eq("reset_flags", {12'h0, FLAGS}, 16'h0000);
`endif

    // ADD R4 = R2 + R3 with a latency check on the FETCH step.
    INS = 16'h0234;
    @(negedge clk);
    btn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check_eq("latency_2nd_edge", OUT, 16'h0000);
    @(posedge clk);
    #1 check_eq("latency_3rd_edge", OUT, 16'h0002);
    @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    press(1);
    check_eq("add_exec", OUT, 16'h0005);
    press(1);
    check_eq("add_wb", OUT, 16'h0005);

    // SUB R4 = R4 - R1, twice.
    run_ins("sub1", 16'h1414, 16'h0005, 16'h0004, 16'h0004);
    run_ins("sub2", 16'h1414, 16'h0004, 16'h0003, 16'h0003);

    // XOR R5 = R5 ^ R6; INS scribbled after FETCH, EXEC button held 10 clks.
    INS = 16'h4565;
    press(1);
    check_eq("xor_fetch", OUT, 16'h0005);
    INS = 16'h0000;
    press(10);
    check_eq("xor_exec_held", OUT, 16'h0003);
    INS = 16'hFFFF;
    press(1);
    check_eq("xor_wb", OUT, 16'h0003);

    // SUB R0 = R0 - R1 -> 0xFFFF (borrow, negative).
    run_ins("sub_neg", 16'h1010, 16'h0000, 16'hFFFF, 16'hFFFF);
`ifdef REG_ALU_FLAGS_EN
    check_eq("sub_neg_flags", {12'h0, FLAGS}, 16'h0006);
`endif

    // Build 0x8000 in R8 and 4 in R9, then SRA R9 = R8 >>> R9.
    run_ins("sll", 16'h61F8, 16'h0001, 16'h8000, 16'h8000);
    run_ins("li4", 16'hD049, 16'hFFFF, 16'h0004, 16'h0004);
    run_ins("sra", 16'h8899, 16'h8000, 16'hF800, 16'hF800);

    // LI R5 = 0x00AB, then MOV R0 = R5 to read it back.
    run_ins("li_ab", 16'hDAB5, 16'h000A, 16'h00AB, 16'h00AB);
    run_ins("mov", 16'hC500, 16'h00AB, 16'h00AB, 16'h00AB);

    // Register state now: R0=AB R1=1 R2=2 R5=AB R6=6 R7=7 R8=8000 R9=F800
    // R10..R15 = index. Each vector writes R13, which none of them reads.
    vecs[0]  = '{16'h267D, 16'h0006, 16'h0006};  // AND  6&7
    vecs[1]  = '{16'h3A5D, 16'h000A, 16'h00AB};  // OR   A|AB
    vecs[2]  = '{16'h580D, 16'h8000, 16'h7FFF};  // NOT  ~8000
    vecs[3]  = '{16'h783D, 16'h8000, 16'h1000};  // SRL  8000>>3
    vecs[4]  = '{16'hA20D, 16'h0002, 16'h0001};  // DEC  2-1
    vecs[5]  = '{16'hB97D, 16'hF800, 16'h0001};  // SLT  -2048<7
    vecs[6]  = '{16'hB79D, 16'h0007, 16'h0000};  // SLT  7<-2048
    vecs[7]  = '{16'hE67D, 16'h0006, 16'hFFF8};  // NOR  ~(6|7)
    vecs[8]  = '{16'hFFED, 16'h000F, 16'hFFF1};  // NAND ~(F&E)
    vecs[9]  = '{16'h9F0D, 16'h000F, 16'h0010};  // INC  F+1
    vecs[10] = '{16'h4A5D, 16'h000A, 16'h00A1};  // XOR  A^AB
    vecs[11] = '{16'h088D, 16'h8000, 16'h0000};  // ADD  8000+8000 wraps
    for (int i = 0; i < 12; i++) begin
      run_ins($sformatf("vec%0d", i), vecs[i].ins, vecs[i].e_f,
              vecs[i].e_x, vecs[i].e_x);
    end
`ifdef REG_ALU_FLAGS_EN
    check_eq("add_wrap_flags", {12'h0, FLAGS}, 16'h000B);
`endif
    run_ins("readback_r13", 16'hCD00, 16'h0000, 16'h0000, 16'h0000);

    // Reset during EXEC of ADD R6 = R1 + R2: no write, back to FETCH.
    INS = 16'h0126;
    press(1);
    check_eq("abort_fetch", OUT, 16'h0001);
    press(1);
    check_eq("abort_exec", OUT, 16'h0003);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("abort_reset_out", OUT, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    INS = 16'hC600;
    press(1);
    check_eq("abort_r6_kept", OUT, 16'h0006);
    press(1);
    check_eq("abort_mov_exec", OUT, 16'h0006);
    press(1);
    check_eq("abort_mov_wb", OUT, 16'h0006);
    // R4 reloaded its reset value of 4.
    run_ins("reset_r4", 16'hC400, 16'h0004, 16'h0004, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
